// File: rtl/dmem_arbiter_pkg.sv
// Shared processor definitions for the data-memory arbiter: default sizes and
// the core-index width helper used by the arbiter and its selector.
package dmem_arbiter_pkg;

  localparam int N_CORES_DEF = 4;
  localparam int DATA_W_DEF  = 16;
  localparam int ADDR_W_DEF  = 16;
  localparam int CORE_IDX_W  = $clog2(N_CORES_DEF);

  // A single-core build still needs a one-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_select.sv
// Round-robin priority selector: first set bit of the eligible vector found
// by searching upward from the pointer, wrapping past the top core.
module dmem_arbiter_rr_select
  import dmem_arbiter_pkg::*;
#(
  parameter int N_CORES = N_CORES_DEF,
  parameter int IDX_W   = CORE_IDX_W
) (
  input  logic [N_CORES-1:0] i_eligible,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_idx
);

  localparam int PW = IDX_W + 1;

  logic [PW-1:0] w_pos;

  // Scanning from the far end lets the candidate closest to the pointer win.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_pos   = '0;
    for (int k = N_CORES - 1; k >= 0; k--) begin
      w_pos = {1'b0, i_ptr} + PW'(k);
      if (w_pos >= PW'(N_CORES)) begin
        w_pos = w_pos - PW'(N_CORES);
      end
      if (i_eligible[w_pos[IDX_W-1:0]]) begin
        o_valid = 1'b1;
        o_idx   = w_pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Multi-core data-memory arbiter: one registered memory access per cycle,
// round-robin among requesters, read data returned one cycle after the grant.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int N_CORES = N_CORES_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  input  logic                      i_arb_en,
  input  logic [N_CORES-1:0]        i_req,
  input  logic [N_CORES-1:0]        i_we,
  input  logic [N_CORES*ADDR_W-1:0] i_addr,
  input  logic [N_CORES*DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0]         i_mem_rdata,
  output logic [N_CORES-1:0]        o_gnt,
  output logic [N_CORES-1:0]        o_rvalid,
  output logic [DATA_W-1:0]         o_rdata,
  output logic                      o_mem_en,
  output logic                      o_mem_we,
  output logic [ADDR_W-1:0]         o_mem_addr,
  output logic [DATA_W-1:0]         o_mem_wdata,
  output logic                      o_busy
);

  localparam int IDX_W = idx_w(N_CORES);

  logic [N_CORES-1:0] r_gnt;
  logic [N_CORES-1:0] r_rvalid;
  logic               r_mem_en;
  logic               r_mem_we;
  logic               r_rd_pending;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic [IDX_W-1:0]   r_rr_ptr;

  logic [N_CORES-1:0] w_eligible;
  logic [N_CORES-1:0] w_gnt_next;
  logic               w_win_valid;
  logic [IDX_W-1:0]   w_win_idx;
  logic [IDX_W-1:0]   w_ptr_next;
  logic               w_sel_we;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wdata;

  // A core granted this cycle is still showing its old req, so mask it out.
  assign w_eligible = i_arb_en ? (i_req & ~r_gnt) : '0;

  dmem_arbiter_rr_select #(
    .N_CORES (N_CORES),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .i_eligible (w_eligible),
    .i_ptr      (r_rr_ptr),
    .o_valid    (w_win_valid),
    .o_idx      (w_win_idx)
  );

  always_comb begin
    w_gnt_next  = '0;
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (w_win_valid && (w_win_idx == IDX_W'(i))) begin
        w_gnt_next[i] = 1'b1;
        w_sel_we      = i_we[i];
        w_sel_addr    = i_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata   = i_wdata[i*DATA_W +: DATA_W];
      end
    end
    w_ptr_next = (w_win_idx == IDX_W'(N_CORES - 1)) ? '0 : w_win_idx + IDX_W'(1);
  end

  // Address and write data hold through idle cycles; only the strobes drop.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_gnt        <= '0;
      r_rvalid     <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_rd_pending <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_rr_ptr     <= '0;
    end else begin
      r_gnt        <= w_gnt_next;
      r_mem_en     <= w_win_valid;
      r_mem_we     <= w_win_valid & w_sel_we;
      r_rd_pending <= r_mem_en & ~r_mem_we;
      r_rvalid     <= (r_mem_en & ~r_mem_we) ? r_gnt : '0;
      if (w_win_valid) begin
        r_mem_addr  <= w_sel_addr;
        r_mem_wdata <= w_sel_wdata;
        r_rr_ptr    <= w_ptr_next;
      end
    end
  end

  assign o_gnt       = r_gnt;
  assign o_rvalid    = r_rvalid;
  assign o_rdata     = i_mem_rdata;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_busy      = (|r_gnt) | r_rd_pending;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model of the arbitration and memory.
module tb_dmem_arbiter;

  localparam int NC = 4;
  localparam int DW = 16;
  localparam int AW = 16;

  logic           clock = 1'b0;
  logic           reset_n = 1'b1;
  logic           arb_en = 1'b0;
  logic [NC-1:0]  req = '0;
  logic [NC-1:0]  we = '0;
  logic [NC*AW-1:0] addr = '0;
  logic [NC*DW-1:0] wdata = '0;
  logic [DW-1:0]  memRdata = '0;

  logic [NC-1:0]  gnt;
  logic [NC-1:0]  rvalid;
  logic [DW-1:0]  rdata;
  logic           memEn;
  logic           memWe;
  logic [AW-1:0]  memAddr;
  logic [DW-1:0]  memWdata;
  logic           busy;

  logic [DW-1:0]  envMem [256] = '{default: '0};

  int checks = 0;
  int failures = 0;

  // Reference model state
  int             mPtr;
  logic [NC-1:0]  mGnt;
  logic [NC-1:0]  mRvalid;
  logic           mMemEn;
  logic           mMemWe;
  logic [AW-1:0]  mAddr;
  logic [DW-1:0]  mWdata;
  logic [DW-1:0]  mRdata;
  logic [DW-1:0]  pendData;
  logic [DW-1:0]  modelMem [256] = '{default: '0};

  always #5 clock = ~clock;

  dmem_arbiter #(.N_CORES(NC), .DATA_W(DW), .ADDR_W(AW)) dut (
    .i_clock     (clock),
    .i_reset_n   (reset_n),
    .i_arb_en    (arb_en),
    .i_req       (req),
    .i_we        (we),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .i_mem_rdata (memRdata),
    .o_gnt       (gnt),
    .o_rvalid    (rvalid),
    .o_rdata     (rdata),
    .o_mem_en    (memEn),
    .o_mem_we    (memWe),
    .o_mem_addr  (memAddr),
    .o_mem_wdata (memWdata),
    .o_busy      (busy)
  );

  // Synchronous memory with one-cycle read latency, aliased on the low address byte.
  always @(posedge clock) begin
    if (memEn) begin
      if (memWe) envMem[memAddr[7:0]] <= memWdata;
      else       memRdata <= envMem[memAddr[7:0]];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPtr    = 0;
    mGnt    = '0;
    mRvalid = '0;
    mMemEn  = 1'b0;
    mMemWe  = 1'b0;
    mAddr   = '0;
    mWdata  = '0;
  endtask

  // One clock edge worth of transactions: deliver last cycle's read, then pick a winner.
  task automatic modelStep();
    logic [NC-1:0] elig;
    logic [AW-1:0] a;
    int win;
    int c;
    mRvalid = (mMemEn && !mMemWe) ? mGnt : '0;
    if (mRvalid != 0) mRdata = pendData;
    elig = arb_en ? (req & ~mGnt) : '0;
    win = -1;
    for (int k = 0; k < NC; k++) begin
      c = (mPtr + k) % NC;
      if (win < 0 && elig[c]) win = c;
    end
    if (win >= 0) begin
      a      = addr[win*AW +: AW];
      mGnt   = NC'(1 << win);
      mMemEn = 1'b1;
      mMemWe = we[win];
      mAddr  = a;
      mWdata = wdata[win*DW +: DW];
      mPtr   = (win + 1) % NC;
      if (we[win]) modelMem[a[7:0]] = mWdata;
      else         pendData = modelMem[a[7:0]];
    end else begin
      mGnt   = '0;
      mMemEn = 1'b0;
      mMemWe = 1'b0;
    end
  endtask

  task automatic checkAll();
    checkOutput("gnt", 32'(gnt), 32'(mGnt));
    checkOutput("rvalid", 32'(rvalid), 32'(mRvalid));
    checkOutput("mem_en", 32'(memEn), 32'(mMemEn));
    checkOutput("mem_we", 32'(memWe), 32'(mMemWe));
    checkOutput("mem_addr", 32'(memAddr), 32'(mAddr));
    checkOutput("mem_wdata", 32'(memWdata), 32'(mWdata));
    checkOutput("busy", 32'(busy), 32'((mGnt != 0) || (mRvalid != 0)));
    if (mRvalid != 0) checkOutput("rdata", 32'(rdata), 32'(mRdata));
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset_n) modelStep();
    @(negedge clock);
    checkAll();
  endtask

  task automatic setCore(input int c, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[c] = r;
    we[c]  = w;
    addr[c*AW +: AW]  = a;
    wdata[c*DW +: DW] = d;
  endtask

  // Random cores honour the handshake: hold until granted, then drop or issue anew.
  task automatic applyStimulus();
    arb_en = ($urandom_range(0, 9) != 0);
    for (int c = 0; c < NC; c++) begin
      if (req[c]) begin
        if (mGnt[c]) begin
          if ($urandom_range(0, 1) == 0) req[c] = 1'b0;
          else setCore(c, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom));
        end
      end else if ($urandom_range(0, 2) == 0) begin
        setCore(c, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom));
      end
    end
  endtask

  initial begin
    modelReset();
    pendData = '0;
    mRdata   = '0;
    #1 reset_n = 1'b0;
    #1 checkAll();
    @(negedge clock);
    reset_n = 1'b1;
    arb_en  = 1'b1;

    // Seed 0x0010 with 0xBEEF, then core 2 reads it back
    setCore(0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
    tick();
    checkOutput("seed_gnt", 32'(gnt), 32'h1);
    req[0] = 1'b0;
    setCore(2, 1'b1, 1'b0, 16'h0010, 16'h0000);
    tick();
    checkOutput("single_gnt", 32'(gnt), 32'b0100);
    req[2] = 1'b0;
    tick();
    checkOutput("single_rvalid", 32'(rvalid), 32'b0100);
    checkOutput("single_rdata", 32'(rdata), 32'hBEEF);

    // Back-to-back write then read of the same address
    setCore(1, 1'b1, 1'b1, 16'h0005, 16'h1234);
    tick();
    checkOutput("b2b_wr_gnt", 32'(gnt), 32'b0010);
    checkOutput("b2b_wr_we", 32'(memWe), 32'h1);
    req[1] = 1'b0;
    setCore(3, 1'b1, 1'b0, 16'h0005, 16'h0000);
    tick();
    checkOutput("b2b_rd_gnt", 32'(gnt), 32'b1000);
    checkOutput("b2b_rd_we", 32'(memWe), 32'h0);
    req[3] = 1'b0;
    tick();
    checkOutput("b2b_rvalid", 32'(rvalid), 32'b1000);
    checkOutput("b2b_rdata", 32'(rdata), 32'h1234);

    // Core 0 leaves req high after its grant while core 1 waits
    setCore(0, 1'b1, 1'b0, 16'h0020, 16'h0000);
    tick();
    checkOutput("stale_gnt0", 32'(gnt), 32'b0001);
    setCore(1, 1'b1, 1'b0, 16'h0021, 16'h0000);
    tick();
    checkOutput("stale_gnt1", 32'(gnt), 32'b0010);
    req[1] = 1'b0;
    tick();
    checkOutput("stale_regnt0", 32'(gnt), 32'b0001);
    req[0] = 1'b0;
    tick();

    // Arbitration disabled with a read in flight
    setCore(2, 1'b1, 1'b0, 16'h0010, 16'h0000);
    tick();
    checkOutput("dis_gnt", 32'(gnt), 32'b0100);
    arb_en = 1'b0;
    req[2] = 1'b0;
    setCore(0, 1'b1, 1'b1, 16'h0030, 16'h7777);
    tick();
    checkOutput("dis_rvalid", 32'(rvalid), 32'b0100);
    checkOutput("dis_nogrant", 32'(gnt), 32'h0);
    tick();
    tick();
    checkOutput("dis_held", 32'(gnt), 32'h0);
    arb_en = 1'b1;
    tick();
    checkOutput("dis_resume", 32'(gnt), 32'b0001);
    req[0] = 1'b0;
    tick();

    // Reset pulsed in the middle of a read
    setCore(1, 1'b1, 1'b0, 16'h0010, 16'h0000);
    tick();
    checkOutput("rst_pre_gnt", 32'(gnt), 32'b0010);
    req[1] = 1'b0;
    #2 reset_n = 1'b0;
    modelReset();
    #1 checkAll();
    tick();
    checkOutput("rst_rvalid", 32'(rvalid), 32'h0);
    for (int c = 0; c < NC; c++) setCore(c, 1'b1, 1'b0, AW'(16'h0040 + c), 16'h0000);
    reset_n = 1'b1;
    tick();
    checkOutput("rst_first_gnt", 32'(gnt), 32'b0001);

    // Full contention continues from core 0 with no idle cycles
    for (int n = 1; n <= 8; n++) begin
      tick();
      checkOutput("contend_gnt", 32'(gnt), 32'(1 << (n % NC)));
    end

    for (int n = 0; n < 1500; n++) begin
      applyStimulus();
      tick();
    end

    req    = '0;
    arb_en = 1'b1;
    tick();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
